// File: rtl/tvth_switch_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tvth_switch_ctrl                                                        |
// | TV/TH polarisation switch driven by the synchronised DDS sweep trigger. |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tvth_switch_ctrl #(
   parameter int BBM_CYCLES   = 2,
   parameter int GUARD_CYCLES = 8,
   parameter int SYNC_STAGES  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        trig_in,
   input  logic [1:0]  mode,
   output logic        tv,
   output logic        th,
   output logic        trig_out,
   output logic        busy,
   output logic        overrun,
   output logic [15:0] sw_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BREAK  = 2'd1,
      ST_SETTLE = 2'd2
   } state_t;

   localparam logic [7:0] C_BBM_LOAD   = 8'(BBM_CYCLES - 1);
   localparam logic [7:0] C_GUARD_LOAD = (GUARD_CYCLES == 0) ? 8'd0 : 8'(GUARD_CYCLES - 1);
   localparam bit         C_NO_GUARD   = (GUARD_CYCLES == 0);

   state_t                 r_state;
   logic [7:0]             r_cnt;
   logic                   r_pol;
   logic                   r_pol_next;
   logic [SYNC_STAGES-1:0] r_sync;

   logic w_s;
   logic w_fe;
   logic w_alt;
   logic w_inc;

   assign w_s   = r_sync[SYNC_STAGES-1];
   assign w_fe  = trig_out & ~w_s;
   assign w_alt = (mode == 2'b11);

   // A switch completes when the last phase counter expires in alternating mode.
   assign w_inc = w_alt && (r_cnt == 8'd0) &&
                  ((r_state == ST_SETTLE) || ((r_state == ST_BREAK) && C_NO_GUARD));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync   <= '0;
         trig_out <= 1'b0;
      end else begin
         r_sync   <= {r_sync[SYNC_STAGES-2:0], trig_in};
         trig_out <= w_s;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= 8'd0;
         r_pol      <= 1'b0;
         r_pol_next <= 1'b0;
         tv         <= 1'b1;
         th         <= 1'b0;
         busy       <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (!w_alt) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_pol   <= 1'b0;
            tv      <= 1'b1;
            th      <= 1'b0;
            busy    <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_fe) begin
                     r_state    <= ST_BREAK;
                     r_cnt      <= C_BBM_LOAD;
                     r_pol_next <= ~r_pol;
                     tv         <= 1'b0;
                     th         <= 1'b0;
                     busy       <= 1'b1;
                  end
               end
               ST_BREAK: begin
                  overrun <= w_fe;
                  if (r_cnt == 8'd0) begin
                     tv <= ~r_pol_next;
                     th <= r_pol_next;
                     if (C_NO_GUARD) begin
                        r_state <= ST_IDLE;
                        r_pol   <= r_pol_next;
                        busy    <= 1'b0;
                     end else begin
                        r_state <= ST_SETTLE;
                        r_cnt   <= C_GUARD_LOAD;
                     end
                  end else begin
                     r_cnt <= r_cnt - 8'd1;
                  end
               end
               ST_SETTLE: begin
                  overrun <= w_fe;
                  if (r_cnt == 8'd0) begin
                     r_state <= ST_IDLE;
                     r_pol   <= r_pol_next;
                     busy    <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt - 8'd1;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sw_cnt <= 16'd0;
      end else begin
         sw_cnt <= sw_cnt + {15'd0, w_inc};
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tvth_switch_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_tvth_switch_ctrl                                                     |
// | Randomised and directed checks against a time-based reference model.    |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tb_tvth_switch_ctrl;

   localparam int BBM   = 2;
   localparam int GUARD = 8;
   localparam int SYNC  = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        trig_in;
   logic [1:0]  mode;
   logic        tv, th, trig_out, busy, overrun;
   logic [15:0] sw_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   tvth_switch_ctrl #(
      .BBM_CYCLES   (BBM),
      .GUARD_CYCLES (GUARD),
      .SYNC_STAGES  (SYNC)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .trig_in  (trig_in),
      .mode     (mode),
      .tv       (tv),
      .th       (th),
      .trig_out (trig_out),
      .busy     (busy),
      .overrun  (overrun),
      .sw_cnt   (sw_cnt)
   );

   // Reference model: a switch is a time window measured from its start edge.
   int          m_edge  = 0;
   int          m_start = 0;
   logic [SYNC-1:0] m_hist = '0;
   logic        m_sd   = 1'b0;
   logic        m_busy = 1'b0;
   logic        m_pol  = 1'b0;
   logic        m_over = 1'b0;
   logic        m_tv   = 1'b1;
   logic        m_th   = 1'b0;
   logic [15:0] m_cnt  = 16'd0;

   task automatic model_edge();
      logic s, fe;
      s  = m_hist[SYNC-1];
      fe = m_sd && !s;
      m_edge++;
      if (rst) begin
         m_hist = '0; m_sd = 1'b0; m_busy = 1'b0; m_pol = 1'b0;
         m_over = 1'b0; m_cnt = 16'd0;
      end else begin
         m_over = (mode == 2'b11) && m_busy && fe;
         if (mode != 2'b11) begin
            m_busy = 1'b0;
            m_pol  = 1'b0;
         end else if (m_busy) begin
            if (m_edge - m_start == BBM + GUARD) begin
               m_busy = 1'b0;
               m_pol  = !m_pol;
               m_cnt  = m_cnt + 16'd1;
            end
         end else if (fe) begin
            m_busy  = 1'b1;
            m_start = m_edge;
         end
         m_sd   = s;
         m_hist = {m_hist[SYNC-2:0], trig_in};
      end
      if (m_busy && (m_edge - m_start) < BBM) begin
         m_tv = 1'b0; m_th = 1'b0;
      end else if (m_busy) begin
         m_tv = m_pol; m_th = !m_pol;
      end else begin
         m_tv = !m_pol; m_th = m_pol;
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      for (int i = 0; i < cycles; i++) tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      trig_in = 1'b1;
      mode    = 2'b11;
      do_reset(3);
      n_tests++;
      if ({tv, th, busy, overrun, trig_out, sw_cnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
         n_fail++;
         $display("FAIL reset_values got tv=%b th=%b busy=%b ovr=%b trig=%b cnt=%h exp 1 0 0 0 0 0000",
                  tv, th, busy, overrun, trig_out, sw_cnt);
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         n_tests++;
         if (busy !== 1'b0 || tv !== 1'b1 || th !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_break cyc=%0d got busy=%b tv=%b th=%b exp 0 1 0", i, busy, tv, th);
         end
      end
   endtask

   task automatic test_single();
      trig_in = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         n_tests++;
         if ({tv, th, busy, overrun, trig_out, sw_cnt} !== {m_tv, m_th, m_busy, m_over, m_sd, m_cnt}) begin
            n_fail++;
            $display("FAIL single_model k=%0d got %b%b%b%b%b/%h exp %b%b%b%b%b/%h", k,
                     tv, th, busy, overrun, trig_out, sw_cnt, m_tv, m_th, m_busy, m_over, m_sd, m_cnt);
         end
         if (k == 3 || k == 4) begin
            n_tests++;
            if ({tv, th, busy} !== 3'b001) begin
               n_fail++;
               $display("FAIL single_break k=%0d got tv/th/busy=%b%b%b exp 001", k, tv, th, busy);
            end
         end
         if (k == 3) begin
            n_tests++;
            if (trig_out !== 1'b0) begin
               n_fail++;
               $display("FAIL single_trig_out got %b exp 0", trig_out);
            end
         end
         if (k == 5) begin
            n_tests++;
            if ({tv, th, busy} !== 3'b011) begin
               n_fail++;
               $display("FAIL single_settle got tv/th/busy=%b%b%b exp 011", tv, th, busy);
            end
         end
         if (k == 12) begin
            n_tests++;
            if (busy !== 1'b1 || sw_cnt !== 16'd0) begin
               n_fail++;
               $display("FAIL single_guard_end got busy=%b cnt=%h exp 1 0000", busy, sw_cnt);
            end
         end
         if (k == 13) begin
            n_tests++;
            if ({tv, th, busy} !== 3'b010 || sw_cnt !== 16'd1) begin
               n_fail++;
               $display("FAIL single_done got tv/th/busy=%b%b%b cnt=%h exp 010 0001", tv, th, busy, sw_cnt);
            end
         end
      end
      trig_in = 1'b1;
      for (int i = 0; i < 5; i++) tick();
   endtask

   task automatic test_alternation();
      logic [1:0] exp_seq [3];
      int ovr_seen;
      exp_seq  = '{2'b01, 2'b10, 2'b01};
      ovr_seen = 0;
      trig_in  = 1'b1;
      mode     = 2'b11;
      do_reset(2);
      for (int e = 0; e < 3; e++) begin
         for (int i = 0; i < 40; i++) begin
            trig_in = (i < 20);
            tick();
            if (overrun) ovr_seen++;
            n_tests++;
            if ({tv, th, busy, overrun, trig_out, sw_cnt} !== {m_tv, m_th, m_busy, m_over, m_sd, m_cnt}) begin
               n_fail++;
               $display("FAIL alt_model e=%0d i=%0d got %b%b%b%b%b/%h exp %b%b%b%b%b/%h", e, i,
                        tv, th, busy, overrun, trig_out, sw_cnt, m_tv, m_th, m_busy, m_over, m_sd, m_cnt);
            end
         end
         n_tests++;
         if ({tv, th} !== exp_seq[e]) begin
            n_fail++;
            $display("FAIL alt_pol e=%0d got tv/th=%b%b exp %b", e, tv, th, exp_seq[e]);
         end
      end
      n_tests++;
      if (sw_cnt !== 16'd3 || ovr_seen != 0) begin
         n_fail++;
         $display("FAIL alt_count got cnt=%h overruns=%0d exp 0003 0", sw_cnt, ovr_seen);
      end
      trig_in = 1'b1;
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_overrun();
      int ovr_seen;
      ovr_seen = 0;
      trig_in  = 1'b1;
      mode     = 2'b11;
      do_reset(2);
      for (int i = 0; i < 6; i++) tick();
      for (int i = 0; i < 30; i++) begin
         trig_in = !(i < 2 || i >= 5);
         tick();
         if (overrun) ovr_seen++;
         n_tests++;
         if ({tv, th, busy, overrun, trig_out, sw_cnt} !== {m_tv, m_th, m_busy, m_over, m_sd, m_cnt}) begin
            n_fail++;
            $display("FAIL ovr_model i=%0d got %b%b%b%b%b/%h exp %b%b%b%b%b/%h", i,
                     tv, th, busy, overrun, trig_out, sw_cnt, m_tv, m_th, m_busy, m_over, m_sd, m_cnt);
         end
      end
      n_tests++;
      if (ovr_seen != 1 || sw_cnt !== 16'd1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL ovr_result got overruns=%0d cnt=%h busy=%b exp 1 0001 0", ovr_seen, sw_cnt, busy);
      end
      trig_in = 1'b1;
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_abort();
      trig_in = 1'b1;
      mode    = 2'b11;
      do_reset(2);
      for (int i = 0; i < 4; i++) tick();
      trig_in = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      n_tests++;
      if ({tv, th, busy} !== 3'b001) begin
         n_fail++;
         $display("FAIL abort_in_break got tv/th/busy=%b%b%b exp 001", tv, th, busy);
      end
      mode = 2'b00;
      tick();
      n_tests++;
      if ({tv, th, busy} !== 3'b100 || sw_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL abort_exit got tv/th/busy=%b%b%b cnt=%h exp 100 0000", tv, th, busy, sw_cnt);
      end
      for (int i = 0; i < 36; i++) begin
         trig_in = ((i / 6) % 2 == 0);
         tick();
         n_tests++;
         if ({tv, th, busy, overrun, sw_cnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL abort_fixed i=%0d got tv/th/busy/ovr=%b%b%b%b cnt=%h exp 1000 0000",
                     i, tv, th, busy, overrun, sw_cnt);
         end
      end
      mode    = 2'b11;
      trig_in = 1'b1;
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_random();
      int seg;
      seg = 0;
      for (int i = 0; i < 3000; i++) begin
         if (seg == 0) begin
            seg     = $urandom_range(1, 24);
            trig_in = 1'($urandom_range(0, 1));
            mode    = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
         end
         seg--;
         rst = ($urandom_range(0, 199) == 0);
         tick();
         n_tests++;
         if ({tv, th, busy, overrun, trig_out, sw_cnt} !== {m_tv, m_th, m_busy, m_over, m_sd, m_cnt}
             || (tv && th)) begin
            n_fail++;
            $display("FAIL rand_model i=%0d got %b%b%b%b%b/%h exp %b%b%b%b%b/%h", i,
                     tv, th, busy, overrun, trig_out, sw_cnt, m_tv, m_th, m_busy, m_over, m_sd, m_cnt);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_wrap_reset();
      trig_in = 1'b1;
      mode    = 2'b11;
      do_reset(2);
      for (int i = 0; i < 4; i++) tick();
      force dut.sw_cnt = 16'hFFFF;
      m_cnt = 16'hFFFF;
      tick();
      release dut.sw_cnt;
      tick();
      n_tests++;
      if (sw_cnt !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL wrap_preload got cnt=%h exp ffff", sw_cnt);
      end
      trig_in = 1'b0;
      for (int i = 0; i < 16; i++) tick();
      n_tests++;
      if (sw_cnt !== 16'h0000 || sw_cnt !== m_cnt) begin
         n_fail++;
         $display("FAIL wrap_result got cnt=%h exp 0000", sw_cnt);
      end
      trig_in = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      trig_in = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      n_tests++;
      if (busy !== 1'b1 || tv === th) begin
         n_fail++;
         $display("FAIL wrap_in_settle got busy=%b tv=%b th=%b exp 1 with tv!=th", busy, tv, th);
      end
      rst = 1'b1;
      tick();
      n_tests++;
      if ({tv, th, busy, overrun, trig_out, sw_cnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
         n_fail++;
         $display("FAIL midswitch_reset got tv=%b th=%b busy=%b ovr=%b trig=%b cnt=%h exp 1 0 0 0 0 0000",
                  tv, th, busy, overrun, trig_out, sw_cnt);
      end
      rst = 1'b0;
      tick();
   endtask

   initial begin
      rst     = 1'b1;
      trig_in = 1'b1;
      mode    = 2'b11;
      test_reset();
      test_single();
      test_alternation();
      test_overrun();
      test_abort();
      test_random();
      test_wrap_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tvth_switch_ctrl.md
# tvth_switch_ctrl

Drives the TV/TH transmit-polarisation switch from the DDS sweep trigger of the first AD9914 channel. It synchronises the trigger into the system clock domain and detects its falling edge. In alternating mode (mode = 2'b11) it toggles polarisation with a break-before-make gap and a settle guard; in every other mode it holds TV selected. It sits between the ad9914_ctrl trig output, the depack mode field and the tv/th pins, and forwards a clock-aligned copy of the trigger.

## Interface
- BBM_CYCLES, 2, cycles with tv and th both low before the new polarisation is driven; legal range 1..255
- GUARD_CYCLES, 8, settle cycles after the new polarisation is driven; legal range 0..255
- SYNC_STAGES, 2, trig_in synchroniser depth; legal range 2..4
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- trig_in  in  1  sweep trigger from ad9914_ctrl, asynchronous to clk
- mode  in  2  depack mode field; 2'b11 = alternating, anything else = fixed TV
- tv  out  1  TV switch drive
- th  out  1  TH switch drive
- trig_out  out  1  synchronised trigger, aligned with tv/th updates
- busy  out  1  high from BREAK entry until SETTLE exits
- overrun  out  1  one-cycle pulse when a falling edge is dropped because busy = 1
- sw_cnt  out  16  number of completed switches; wraps from 0xFFFF to 0

## Operation
- Synchroniser: SYNC_STAGES flops on trig_in, all reset to 0. s is the last stage; s_d is s delayed one cycle. A falling edge fe = s_d & ~s.
- trig_out is s_d, registered.
- States:
  - IDLE: busy = 0. tv/th hold their current polarisation.
  - BREAK: tv = th = 0. A counter loads BBM_CYCLES-1 and counts down to 0.
  - SETTLE: drives pol_next (the complement of the polarisation held at BREAK entry). A counter loads GUARD_CYCLES-1 and counts down to 0.
- Transitions:
  - IDLE→BREAK on fe while mode == 2'b11.
  - BREAK→SETTLE when the BBM counter reaches 0.
  - SETTLE→IDLE when the guard counter reaches 0; sw_cnt increments on this transition.
  - If GUARD_CYCLES = 0, BREAK goes straight to IDLE with pol_next driven, and sw_cnt increments.
- Polarisation encoding: pol = 0 means tv = 1, th = 0; pol = 1 means tv = 0, th = 1. tv and th must never both be 1.
- Fixed mode: if mode != 2'b11 in any cycle:
  - the state is forced to IDLE;
  - pol is set to 0, so tv = 1, th = 0, on the next edge;
  - an in-progress switch is aborted and sw_cnt does not increment.
  - fe is ignored in fixed mode.
- overrun: fe in BREAK or SETTLE while mode == 2'b11 pulses overrun for one cycle. The edge is discarded and does not queue a second switch.
- Counter width is 8 bits. sw_cnt is a plain 16-bit wrap-around increment.
- Reset values: tv = 1, th = 0, trig_out = 0, busy = 0, overrun = 0, sw_cnt = 0, state = IDLE, pol = 0, all synchroniser flops = 0.
  - A trig_in held high through reset release produces no fe.
- rst asserted mid-switch returns every output to its reset value on the next edge.

## Timing
- Let trig_in go low before edge E0 and meet setup for it.
  - s goes low at edge E0+SYNC_STAGES-1.
  - fe is valid in the following cycle.
  - At edge E0+SYNC_STAGES: state = BREAK, tv = th = 0, busy = 1.
- trig_out falls at edge E0+SYNC_STAGES, the same edge tv/th drop.
- tv/th = pol_next at edge E0+SYNC_STAGES+BBM_CYCLES.
- busy falls and sw_cnt increments at edge E0+SYNC_STAGES+BBM_CYCLES+GUARD_CYCLES.
- Minimum spacing between trigger falling edges that are all honoured: BBM_CYCLES+GUARD_CYCLES+1 cycles.
- overrun is high in the cycle after the dropped fe, i.e. the cycle in which the state would otherwise have changed.
- A mode change to fixed takes effect one clock after mode is sampled. busy is 0 and tv/th are 1/0 at the same edge.

## Test plan
- Reset: drive rst = 1 for 3 cycles with trig_in = 1 and mode = 2'b11, then release → tv = 1, th = 0, busy = 0, sw_cnt = 0, and no BREAK entry until trig_in first falls.
- Single switch with defaults (BBM = 2, GUARD = 8, SYNC = 2) and mode = 2'b11; trig_in 1→0 before E0 → tv/th = 0/0 at E0+2 and E0+3, 0/1 at E0+4, busy low and sw_cnt = 1 at E0+12.
- Alternation: send three falling edges 40 cycles apart → tv/th sequence (after settle) is 0/1, 1/0, 0/1; sw_cnt = 3; overrun never asserted.
- Overrun: send a second falling edge 5 cycles after the first → exactly one overrun pulse, a single switch completes, sw_cnt = 1.
- Abort: mode goes 2'b11→2'b00 while in BREAK → next edge tv = 1, th = 0, busy = 0, sw_cnt unchanged; further trig edges cause no switching.
- Wrap and reset mid-switch: preload sw_cnt = 0xFFFF via 65535 switches (or by forcing the counter), one more switch → 0x0000. Then assert rst during SETTLE → all outputs return to reset values on the next edge.
